// File: rtl/trace_pkg.sv
// Shared record types for the commit/flush/hang trace transmitter.
// A record is two 32-bit words on the wire: {type, info, timestamp} then payload.
package trace_pkg;

    localparam int unsigned TRACE_TS_W  = 24;
    localparam int unsigned TRACE_REC_W = 2 + 6 + TRACE_TS_W + 32;

    typedef enum logic [1:0] {
        COMMIT = 2'b01,
        FLUSH  = 2'b10,
        HANG   = 2'b11
    } trace_type_t;

    typedef struct packed {
        trace_type_t             rtype;
        logic [5:0]              info;
        logic [TRACE_TS_W-1:0]   ts;
        logic [31:0]             payload;
    } trace_rec_t;

    typedef enum logic {
        TX_W0 = 1'b0,
        TX_W1 = 1'b1
    } tx_state_t;

    function automatic logic [31:0] rec_word0(input trace_rec_t rec);
        return {rec.rtype, rec.info, rec.ts};
    endfunction

endpackage

// File: rtl/trace_fifo_2w.sv
// Record FIFO with two ordered write ports and one read port.
// o_free reflects the registered occupancy, so a pop frees its slot one cycle later.
module trace_fifo_2w
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr0_en,
    input  logic [TRACE_REC_W-1:0]   i_wr0_rec,
    input  logic                     i_wr1_en,
    input  logic [TRACE_REC_W-1:0]   i_wr1_rec,
    input  logic                     i_pop,
    output logic [TRACE_REC_W-1:0]   o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [TRACE_REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;

    logic [1:0]             w_n_wr;
    logic [AW-1:0]          w_wr1_idx;
    logic                   w_pop;

    always_comb begin
        w_n_wr    = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};
        w_wr1_idx = i_wr0_en ? r_wr_ptr + AW'(1) : r_wr_ptr;
        w_pop     = i_pop && (r_count != '0);
    end

    always_ff @(posedge clk) begin
        if (i_wr0_en) r_mem[r_wr_ptr]  <= i_wr0_rec;
        if (i_wr1_en) r_mem[w_wr1_idx] <= i_wr1_rec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_wr);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= r_count + (AW+1)'(w_n_wr) - (AW+1)'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_free  = (AW+1)'(DEPTH) - r_count;

endmodule

// File: rtl/commit_trace_tx.sv
// Captures commit/flush/hang events as timestamped records and streams them
// out two words per record over a valid/ready port.
module commit_trace_tx
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HANG_CYCLES = 500,
    parameter int unsigned DROP_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_valid,
    input  logic              commit_flushed,
    input  logic              commit_valid_write,
    input  logic [5:0]        commit_pdst,
    input  logic [31:0]       commit_data,
    input  logic              flush_valid,
    input  logic [31:0]       flush_address,
    input  logic [2:0]        flush_rob_ticket,
    input  logic [1:0]        flush_rat_id,
    input  logic              flush_delayed,
    input  logic [31:0]       current_pc,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_data,
    output logic              trace_last,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              hang_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned HCW = $clog2(HANG_CYCLES + 1);

    logic [TRACE_TS_W-1:0] r_ts;
    logic [31:0]           r_prev_pc;
    logic [HCW-1:0]        r_hang_cnt;
    logic                  r_hang_o;
    logic                  r_hang_pend;
    logic [TRACE_TS_W-1:0] r_hang_ts;
    logic [31:0]           r_hang_pc;
    logic [DROP_W-1:0]     r_drop;
    tx_state_t             r_state;

    logic                  w_commit_ev;
    logic                  w_flush_ev;
    trace_rec_t            w_commit_rec;
    trace_rec_t            w_flush_rec;
    trace_rec_t            w_hang_rec;
    logic [AW:0]           w_free;
    logic                  w_commit_acc;
    logic                  w_flush_acc;
    logic                  w_hang_acc;
    logic [1:0]            w_n_acc;
    logic [1:0]            w_n_drop;
    logic                  w_wr0_en;
    logic                  w_wr1_en;
    trace_rec_t            w_wr0_rec;
    trace_rec_t            w_wr1_rec;
    logic [DROP_W:0]       w_drop_sum;
    logic                  w_hang_hit;
    logic [TRACE_REC_W-1:0] w_head;
    trace_rec_t            w_head_rec;
    logic                  w_empty;
    logic                  w_pop;

    always_comb begin
        w_commit_ev  = commit_valid && !commit_flushed && commit_valid_write;
        w_flush_ev   = flush_valid;
        w_commit_rec = '{rtype: COMMIT, info: commit_pdst, ts: r_ts, payload: commit_data};
        w_flush_rec  = '{rtype: FLUSH,
                         info: {flush_rob_ticket, flush_rat_id, flush_delayed},
                         ts: r_ts, payload: flush_address};
        w_hang_rec   = '{rtype: HANG, info: '0, ts: r_hang_ts, payload: r_hang_pc};

        // Slot allocation in priority order commit, flush, then the pending hang
        // record, which only takes a slot the other two left over.
        w_commit_acc = w_commit_ev && (w_free >= (AW+1)'(1));
        w_flush_acc  = w_flush_ev && (w_free >= (w_commit_acc ? (AW+1)'(2) : (AW+1)'(1)));
        w_n_acc      = {1'b0, w_commit_acc} + {1'b0, w_flush_acc};
        w_hang_acc   = r_hang_pend && (w_n_acc != 2'd2) && (w_free > (AW+1)'(w_n_acc));
        w_n_drop     = {1'b0, w_commit_ev && !w_commit_acc} + {1'b0, w_flush_ev && !w_flush_acc};

        w_wr0_en  = w_commit_acc || w_flush_acc || w_hang_acc;
        w_wr0_rec = w_commit_acc ? w_commit_rec : (w_flush_acc ? w_flush_rec : w_hang_rec);
        w_wr1_en  = (w_commit_acc && (w_flush_acc || w_hang_acc)) || (w_flush_acc && w_hang_acc);
        w_wr1_rec = (w_commit_acc && w_flush_acc) ? w_flush_rec : w_hang_rec;

        w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(w_n_drop);
        w_hang_hit = (r_hang_cnt == HCW'(HANG_CYCLES)) && !r_hang_o;
    end

    trace_fifo_2w #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr0_en  (w_wr0_en),
        .i_wr0_rec (w_wr0_rec),
        .i_wr1_en  (w_wr1_en),
        .i_wr1_rec (w_wr1_rec),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_empty   (w_empty),
        .o_free    (w_free)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts        <= '0;
            r_prev_pc   <= '0;
            r_hang_cnt  <= '0;
            r_hang_o    <= 1'b0;
            r_hang_pend <= 1'b0;
            r_hang_ts   <= '0;
            r_hang_pc   <= '0;
            r_drop      <= '0;
        end else begin
            r_ts      <= r_ts + TRACE_TS_W'(1);
            r_prev_pc <= current_pc;
            // Counter parks at the threshold; the sticky flag blocks re-arming.
            if (current_pc != r_prev_pc) begin
                r_hang_cnt <= '0;
            end else if (r_hang_cnt != HCW'(HANG_CYCLES)) begin
                r_hang_cnt <= r_hang_cnt + HCW'(1);
            end
            if (w_hang_hit) begin
                r_hang_o    <= 1'b1;
                r_hang_pend <= 1'b1;
                r_hang_ts   <= r_ts;
                r_hang_pc   <= current_pc;
            end else if (w_hang_acc) begin
                r_hang_pend <= 1'b0;
            end
            r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TX_W0;
        end else if (!w_empty && trace_ready) begin
            r_state <= (r_state == TX_W0) ? TX_W1 : TX_W0;
        end
    end

    assign w_head_rec  = w_head;
    assign w_pop       = (r_state == TX_W1) && !w_empty && trace_ready;
    assign trace_valid = !w_empty;
    assign trace_last  = !w_empty && (r_state == TX_W1);
    assign trace_data  = w_empty ? '0 :
                         ((r_state == TX_W1) ? w_head_rec.payload : rec_word0(w_head_rec));
    assign drop_cnt    = r_drop;
    assign hang_o      = r_hang_o;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: record layout, ordering, backpressure,
// overflow and drop saturation, hang record, and reset mid-record.
module tb_commit_trace_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_valid = 1'b0;
    logic        commit_flushed = 1'b0;
    logic        commit_valid_write = 1'b0;
    logic [5:0]  commit_pdst = '0;
    logic [31:0] commit_data = '0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_address = '0;
    logic [2:0]  flush_rob_ticket = '0;
    logic [1:0]  flush_rat_id = '0;
    logic        flush_delayed = 1'b0;
    logic [31:0] current_pc = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_data;
    logic        trace_last;
    logic [15:0] drop_cnt;
    logic        hang_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    commit_trace_tx #(
        .DEPTH       (8),
        .HANG_CYCLES (500),
        .DROP_W      (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .commit_valid       (commit_valid),
        .commit_flushed     (commit_flushed),
        .commit_valid_write (commit_valid_write),
        .commit_pdst        (commit_pdst),
        .commit_data        (commit_data),
        .flush_valid        (flush_valid),
        .flush_address      (flush_address),
        .flush_rob_ticket   (flush_rob_ticket),
        .flush_rat_id       (flush_rat_id),
        .flush_delayed      (flush_delayed),
        .current_pc         (current_pc),
        .trace_valid        (trace_valid),
        .trace_ready        (trace_ready),
        .trace_data         (trace_data),
        .trace_last         (trace_last),
        .drop_cnt           (drop_cnt),
        .hang_o             (hang_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        commit_valid       = 1'b0;
        commit_flushed     = 1'b0;
        commit_valid_write = 1'b0;
        flush_valid        = 1'b0;
    endtask

    task automatic drive_commit(input logic [5:0] pdst, input logic [31:0] data);
        commit_valid       = 1'b1;
        commit_flushed     = 1'b0;
        commit_valid_write = 1'b1;
        commit_pdst        = pdst;
        commit_data        = data;
    endtask

    task automatic drive_flush(input logic [31:0] addr, input logic [2:0] rob,
                               input logic [1:0] rat, input logic dly);
        flush_valid      = 1'b1;
        flush_address    = addr;
        flush_rob_ticket = rob;
        flush_rat_id     = rat;
        flush_delayed    = dly;
    endtask

    // Ends on a falling edge with reset released; the next rising edge is cycle ts=0.
    task automatic reset_dut();
        rst_n = 1'b0;
        clear_events();
        trace_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Captures one presented word and lets it handshake (trace_ready must be high).
    task automatic wait_word(output logic [31:0] d, output logic l, output bit ok);
        ok = 1'b0;
        d  = '0;
        l  = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            if (trace_valid === 1'b1) begin
                d  = trace_data;
                l  = trace_last;
                ok = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_commit(6'd3, 32'h1111_1111);
        drive_flush(32'h2222_2222, 3'd1, 2'd1, 1'b1);
        trace_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (trace_valid !== 1'b0 || trace_data !== 32'h0 || trace_last !== 1'b0 ||
            drop_cnt !== 16'h0 || hang_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: valid=%b data=%h last=%b drop=%0d hang=%b want all zero",
                     trace_valid, trace_data, trace_last, drop_cnt, hang_o);
        end
        reset_dut();
        repeat (3) step();
        total++;
        if (trace_valid !== 1'b0 || trace_data !== 32'h0 || trace_last !== 1'b0 ||
            drop_cnt !== 16'h0 || hang_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: valid=%b data=%h last=%b drop=%0d hang=%b want all zero",
                     trace_valid, trace_data, trace_last, drop_cnt, hang_o);
        end
    endtask

    task automatic test_single_commit();
        reset_dut();
        trace_ready = 1'b1;
        repeat (5) step();
        drive_commit(6'd9, 32'hDEAD_BEEF);
        step();
        clear_events();
        total++;
        if (trace_valid !== 1'b1 || trace_data !== 32'h4900_0005 || trace_last !== 1'b0) begin
            bad++;
            $display("FAIL single_w0: valid=%b data=%h last=%b want 1 49000005 0",
                     trace_valid, trace_data, trace_last);
        end
        step();
        total++;
        if (trace_valid !== 1'b1 || trace_data !== 32'hDEAD_BEEF || trace_last !== 1'b1) begin
            bad++;
            $display("FAIL single_w1: valid=%b data=%h last=%b want 1 deadbeef 1",
                     trace_valid, trace_data, trace_last);
        end
        step();
        total++;
        if (trace_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: valid=%b want 0", trace_valid);
        end
    endtask

    task automatic test_commit_flush();
        logic [31:0] exp_d [4];
        logic        exp_l [4];
        logic [31:0] d;
        logic        l;
        bit          ok;
        reset_dut();
        trace_ready = 1'b1;
        drive_commit(6'd1, 32'h1);
        commit_flushed = 1'b1;
        step();
        drive_commit(6'd2, 32'h2);
        commit_valid_write = 1'b0;
        step();
        clear_events();
        total++;
        if (trace_valid !== 1'b0) begin
            bad++;
            $display("FAIL filtered_commit: valid=%b want 0", trace_valid);
        end
        step();
        drive_commit(6'd5, 32'h1234_5678);
        drive_flush(32'h0000_0100, 3'd3, 2'd2, 1'b1);
        step();
        clear_events();
        exp_d[0] = 32'h4500_0003; exp_l[0] = 1'b0;
        exp_d[1] = 32'h1234_5678; exp_l[1] = 1'b1;
        exp_d[2] = 32'h9D00_0003; exp_l[2] = 1'b0;
        exp_d[3] = 32'h0000_0100; exp_l[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_word(d, l, ok);
            total++;
            if (!ok || d !== exp_d[i] || l !== exp_l[i]) begin
                bad++;
                $display("FAIL commit_flush[%0d]: seen=%b data=%h last=%b want %h %b",
                         i, ok, d, l, exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [6];
        logic        exp_l [6];
        logic [31:0] d;
        logic        l;
        bit          ok;
        reset_dut();
        drive_commit(6'd1, 32'hA0A0_A0A0);
        drive_flush(32'h0000_0200, 3'd0, 2'd1, 1'b0);
        step();
        clear_events();
        drive_commit(6'd2, 32'hC0C0_C0C0);
        step();
        clear_events();
        for (int i = 0; i < 20; i++) begin
            total++;
            if (trace_valid !== 1'b1 || trace_data !== 32'h4100_0000 || trace_last !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h last=%b want 1 41000000 0",
                         i, trace_valid, trace_data, trace_last);
            end
            step();
        end
        trace_ready = 1'b1;
        exp_d[0] = 32'h4100_0000; exp_l[0] = 1'b0;
        exp_d[1] = 32'hA0A0_A0A0; exp_l[1] = 1'b1;
        exp_d[2] = 32'h8200_0000; exp_l[2] = 1'b0;
        exp_d[3] = 32'h0000_0200; exp_l[3] = 1'b1;
        exp_d[4] = 32'h4200_0001; exp_l[4] = 1'b0;
        exp_d[5] = 32'hC0C0_C0C0; exp_l[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_word(d, l, ok);
            total++;
            if (!ok || d !== exp_d[i] || l !== exp_l[i]) begin
                bad++;
                $display("FAIL bp_order[%0d]: seen=%b data=%h last=%b want %h %b",
                         i, ok, d, l, exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_d [16];
        logic        exp_l [16];
        logic [31:0] d;
        logic        l;
        bit          ok;
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            drive_commit(6'(k + 1), 32'h1000 + k);
            drive_flush(32'h2000 + k, 3'(k), 2'(k), k[0]);
            step();
        end
        clear_events();
        total++;
        if (drop_cnt !== 16'd4 || trace_valid !== 1'b1) begin
            bad++;
            $display("FAIL overflow_drop: drop=%0d valid=%b want 4 1", drop_cnt, trace_valid);
        end
        for (int k = 0; k < 4; k++) begin
            exp_d[4*k]   = {2'b01, 6'(k + 1), 24'(k)};
            exp_d[4*k+1] = 32'h1000 + k;
            exp_d[4*k+2] = {2'b10, 3'(k), 2'(k), k[0], 24'(k)};
            exp_d[4*k+3] = 32'h2000 + k;
            exp_l[4*k]   = 1'b0;
            exp_l[4*k+1] = 1'b1;
            exp_l[4*k+2] = 1'b0;
            exp_l[4*k+3] = 1'b1;
        end
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_word(d, l, ok);
            total++;
            if (!ok || d !== exp_d[i] || l !== exp_l[i]) begin
                bad++;
                $display("FAIL overflow_order[%0d]: seen=%b data=%h last=%b want %h %b",
                         i, ok, d, l, exp_d[i], exp_l[i]);
            end
        end
        repeat (4) step();
        total++;
        if (trace_valid !== 1'b0) begin
            bad++;
            $display("FAIL overflow_extra: valid=%b want 0", trace_valid);
        end
    endtask

    task automatic test_drop_saturate();
        reset_dut();
        // Four cycles fill the FIFO, then each cycle drops two records.
        for (int k = 0; k < 4 + 32767; k++) begin
            drive_commit(6'd1, 32'h0);
            drive_flush(32'h0, 3'd0, 2'd0, 1'b0);
            current_pc = current_pc ^ 32'h4;
            step();
        end
        total++;
        if (drop_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL drop_near_sat: drop=%h want fffe", drop_cnt);
        end
        step();
        total++;
        if (drop_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL drop_sat: drop=%h want ffff", drop_cnt);
        end
        step();
        clear_events();
        total++;
        if (drop_cnt !== 16'hFFFF || hang_o !== 1'b0) begin
            bad++;
            $display("FAIL drop_hold: drop=%h hang=%b want ffff 0", drop_cnt, hang_o);
        end
        current_pc = '0;
    endtask

    task automatic test_hang();
        logic [31:0] d;
        logic        l;
        bit          ok;
        bit          extra;
        current_pc = 32'h0000_0040;
        reset_dut();
        trace_ready = 1'b1;
        repeat (501) step();
        total++;
        if (hang_o !== 1'b0 || trace_valid !== 1'b0) begin
            bad++;
            $display("FAIL hang_early: hang=%b valid=%b want 0 0", hang_o, trace_valid);
        end
        step();
        total++;
        if (hang_o !== 1'b1) begin
            bad++;
            $display("FAIL hang_rise: hang=%b want 1", hang_o);
        end
        wait_word(d, l, ok);
        total++;
        if (!ok || d !== 32'hC000_01F5 || l !== 1'b0) begin
            bad++;
            $display("FAIL hang_w0: seen=%b data=%h last=%b want c00001f5 0", ok, d, l);
        end
        wait_word(d, l, ok);
        total++;
        if (!ok || d !== 32'h0000_0040 || l !== 1'b1) begin
            bad++;
            $display("FAIL hang_w1: seen=%b data=%h last=%b want 00000040 1", ok, d, l);
        end
        extra = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (trace_valid !== 1'b0) extra = 1'b1;
            step();
        end
        total++;
        if (extra || hang_o !== 1'b1) begin
            bad++;
            $display("FAIL hang_once: extra_record=%b hang=%b want 0 1", extra, hang_o);
        end
        current_pc = '0;
    endtask

    task automatic test_reset_mid_record();
        logic [31:0] d;
        logic        l;
        bit          ok;
        bit          stale;
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            drive_commit(6'(k + 1), 32'h3000 + k);
            drive_flush(32'h4000 + k, 3'd0, 2'd0, 1'b0);
            step();
        end
        clear_events();
        total++;
        if (drop_cnt !== 16'd2) begin
            bad++;
            $display("FAIL mid_drop: drop=%0d want 2", drop_cnt);
        end
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        total++;
        if (trace_valid !== 1'b1 || trace_last !== 1'b1 || trace_data !== 32'h0000_3000) begin
            bad++;
            $display("FAIL mid_w1: valid=%b last=%b data=%h want 1 1 00003000",
                     trace_valid, trace_last, trace_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (trace_valid !== 1'b0 || trace_data !== 32'h0 || trace_last !== 1'b0 ||
            drop_cnt !== 16'h0 || hang_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: valid=%b data=%h last=%b drop=%0d hang=%b want all zero",
                     trace_valid, trace_data, trace_last, drop_cnt, hang_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        trace_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (trace_valid !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++;
            $display("FAIL mid_stale: valid seen after reset, want none");
        end
        drive_commit(6'd7, 32'h0000_0077);
        step();
        clear_events();
        wait_word(d, l, ok);
        total++;
        if (!ok || d !== 32'h4700_000C || l !== 1'b0) begin
            bad++;
            $display("FAIL mid_fresh_w0: seen=%b data=%h last=%b want 4700000c 0", ok, d, l);
        end
        wait_word(d, l, ok);
        total++;
        if (!ok || d !== 32'h0000_0077 || l !== 1'b1) begin
            bad++;
            $display("FAIL mid_fresh_w1: seen=%b data=%h last=%b want 00000077 1", ok, d, l);
        end
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_commit_flush();
        test_backpressure();
        test_overflow();
        test_drop_saturate();
        test_hang();
        test_reset_mid_record();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_tx.md
# commit_trace_tx

Synthesizable commit/flush trace transmitter for the out-of-order core. Captures every architecturally committed register write, every pipeline flush and a PC-hang event from `top_processor`. Queues them as timestamped two-word records and streams them out over a 32-bit valid/ready port to an off-core debug reader. It is the hardware producer of the same commit/flush/hang event stream that the simulation monitor consumes, so silicon and FPGA runs can produce comparable traces.

## Interface
Parameters:
- `DEPTH`, 8: record FIFO entries. Power of 2, ≥4.
- `HANG_CYCLES`, 500: consecutive cycles with unchanged PC that raise a hang.
- `DROP_W`, 16: width of the dropped-record counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `commit_valid`  in  1  `writeback_toARF.valid_commit`.
- `commit_flushed`  in  1  `writeback_toARF.flushed`.
- `commit_valid_write`  in  1  `writeback_toARF.valid_write`.
- `commit_pdst`  in  6  physical destination register.
- `commit_data`  in  32  written data.
- `flush_valid`  in  1  flush issued this cycle.
- `flush_address`  in  32  redirect address.
- `flush_rob_ticket`  in  3  ROB ticket of the flushing instruction.
- `flush_rat_id`  in  2  RAT checkpoint id.
- `flush_delayed`  in  1  delayed-capture flag from the flush controller.
- `current_pc`  in  32  fetch PC.
- `trace_valid`  out  1  output word valid.
- `trace_ready`  in  1  reader accepts word.
- `trace_data`  out  32  output word.
- `trace_last`  out  1  high on the second word of a record.
- `drop_cnt`  out  `DROP_W`  count of records lost to a full FIFO; saturates at all-ones.
- `hang_o`  out  1  sticky hang flag.

## Operation
- **Commit event:** `commit_valid & ~commit_flushed & commit_valid_write`. Flush event: `flush_valid`.
- **Timestamp:** 24-bit free-running counter. Resets to 0, increments every cycle, wraps. Each record carries the counter value of its event cycle.
- **Record layout.**
  - Word0 = {type[31:30], info[29:24], ts[23:0]}.
  - Word1 = payload.
  - Commit: type 01, info = `pdst`, payload = `data`.
  - Flush: type 10, info = {`rob_ticket`, `rat_id`, `delayed`}, payload = `flush_address`.
  - Hang: type 11, info = 0, payload = `current_pc`.
- **Enqueue.** Up to 2 records per cycle; the write pointer advances by 0, 1 or 2.
  - Order when both are present: commit, then flush.
  - Each record that does not fit in the free slots is dropped and increments `drop_cnt` by 1.
  - If commit and flush both drop, `drop_cnt` increments by 2; it saturates and never wraps.
- **Hang detector.**
  - Counter resets to 0 whenever `current_pc` differs from the PC registered in the previous cycle; otherwise it increments.
  - When it reaches `HANG_CYCLES`:
    - `hang_o` sets and stays set until reset.
    - A hang record becomes pending.
  - The pending hang record enqueues in the first cycle where a slot remains free after that cycle's commit/flush records. It is never dropped and is emitted exactly once.
- **Transmitter.** Two states:
  - **W0:** presents Word0 of the head entry with `trace_last` = 0. When `trace_valid & trace_ready` → W1.
  - **W1:** presents Word1 with `trace_last` = 1. On handshake: pop the entry, → W0.
- **Handshake rules.**
  - `trace_valid` = FIFO non-empty.
  - `trace_data` and `trace_last` hold stable while `trace_valid & ~trace_ready`.
  - `trace_valid` never deasserts without a handshake.
- **Full FIFO.** An entry popped in a cycle does not free its slot for enqueue until the next cycle.

## Timing
- **Reset values:**
  - `trace_valid` = 0, `trace_data` = 0, `trace_last` = 0, `drop_cnt` = 0, `hang_o` = 0.
  - FIFO empty, transmitter in W0, timestamp = 0, hang counter = 0.
  - The registered previous PC resets to 0.
- **Latency:**
  - An event in cycle N is visible on `trace_valid` in cycle N+1 when the FIFO was empty.
  - With `trace_ready` held high, one record drains every 2 cycles.
- **Hang flag:** `hang_o` rises in the cycle after the counter reaches `HANG_CYCLES`.
- **Reset mid-record:** the partially sent record is discarded, and so is all FIFO contents.

## Structure
- Shared package `trace_pkg`:
  - `trace_type_t` enum (COMMIT = 01, FLUSH = 10, HANG = 11).
  - `trace_rec_t` packed struct {type, info, ts, payload}.
  - Timestamp width constant `TRACE_TS_W` = 24.
- Sub-module `trace_fifo_2w`: DEPTH-entry FIFO with 2 write ports, 1 read port, and a free-count output. Enqueue/drop decisions use the free count.
- The top level holds the event decode, the timestamp and hang counters, and the W0/W1 serializer.

## Test plan
- **Single commit.** After reset, commit {pdst = 9, data = 0xDEADBEEF} at ts = 5, `trace_ready` = 1. Expected: Word0 0x4900_0005 then Word1 0xDEADBEEF with `trace_last` = 1.
- **Simultaneous commit + flush.** Same cycle, flush {addr = 0x100, rob = 3, rat = 2, delayed = 1}. Expected: the commit record, then flush Word0 = {10, 011101, ts} and Word1 = 0x0000_0100.
- **Backpressure.** `trace_ready` low for 20 cycles with 3 records queued. Expected: Word0 of the head record holds stable; order is preserved after release; `trace_last` pattern is 0,1,0,1,0,1.
- **Overflow.** DEPTH = 8, `trace_ready` = 0, 6 cycles of commit+flush (12 records). Expected: 8 records queued, `drop_cnt` = 4, and the first 8 records emitted in order after release.
- **Hang.** Hold `current_pc` = 0x0000_0040 for 500 cycles. Expected: `hang_o` = 1, one hang record with payload 0x40. A further 500 cycles adds no second record.
- **Reset mid-record.** Assert `rst_n` low while in W1 with `trace_valid` high. Expected: all outputs 0 immediately; after release, no stale word is emitted.
